// File: rtl/com_tx_sched.sv
// Transmit scheduler: fixed-priority arbitration (handshake > status > data), fs/fd handshake
// with the packet serializer, watchdog abort, inter-packet gap and DATA0/DATA1 toggle.
module com_tx_sched #(
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned TIMEOUT    = 4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hs_req,
   input  logic [1:0]  hs_type,
   output logic        hs_done,
   input  logic        st_req,
   input  logic [1:0]  st_type,
   input  logic [11:0] st_init,
   input  logic [11:0] st_rlen,
   output logic        st_done,
   input  logic        dt_req,
   input  logic        dt_retry,
   input  logic [11:0] dt_init,
   input  logic [11:0] dt_rlen,
   output logic        dt_done,
   output logic        tx_fs,
   input  logic        tx_fd,
   output logic [3:0]  tx_btype,
   output logic [11:0] tx_init,
   output logic [11:0] tx_rlen,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {StIdle, StLoad, StSend, StRels, StAbrt, StGap} state_e;

   localparam logic [15:0] WdogLast = 16'(TIMEOUT - 1);
   localparam logic [7:0]  GapLast  = 8'(GAP_CYCLES - 1);

   state_e      state_q;
   logic [2:0]  gnt_q;   // one-hot {dt, st, hs}
   logic [2:0]  done_q;
   logic        retry_q;
   logic        toggle_q;
   logic        fs_q;
   logic        busy_q;
   logic        err_q;
   logic [3:0]  btype_q;
   logic [11:0] init_q;
   logic [11:0] rlen_q;
   logic [15:0] wdog_q;
   logic [7:0]  gap_q;

   logic [2:0]  sel_gnt;
   logic        sel_ok;
   logic [3:0]  sel_btype;
   logic [11:0] sel_init;
   logic [11:0] sel_rlen;
   logic        dt_pid;

   // Winner and its descriptor, evaluated every cycle but only used in StIdle.
   always_comb begin
      dt_pid    = toggle_q ^ dt_retry;
      sel_gnt   = 3'b000;
      sel_ok    = 1'b0;
      sel_btype = 4'b0000;
      sel_init  = 12'h000;
      sel_rlen  = 12'h000;
      if (hs_req) begin
         sel_gnt   = 3'b001;
         sel_ok    = (hs_type != 2'b00);
         sel_btype = {2'b00, hs_type};
      end else if (st_req) begin
         sel_gnt   = 3'b010;
         sel_ok    = (st_type != 2'b11) && (st_rlen != 12'h000);
         sel_btype = {2'b10, st_type};
         sel_init  = st_init;
         sel_rlen  = st_rlen;
      end else if (dt_req) begin
         sel_gnt   = 3'b100;
         sel_ok    = (dt_rlen != 12'h000);
         sel_btype = dt_pid ? 4'b1110 : 4'b1101;
         sel_init  = dt_init;
         sel_rlen  = dt_rlen;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         gnt_q    <= 3'b000;
         done_q   <= 3'b000;
         retry_q  <= 1'b0;
         toggle_q <= 1'b0;
         fs_q     <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         btype_q  <= 4'b0000;
         init_q   <= 12'h000;
         rlen_q   <= 12'h000;
         wdog_q   <= 16'h0000;
         gap_q    <= 8'h00;
      end else begin
         done_q <= 3'b000;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (sel_gnt != 3'b000) begin
                  gnt_q   <= sel_gnt;
                  retry_q <= dt_retry;
                  busy_q  <= 1'b1;
                  if (sel_ok) begin
                     state_q <= StLoad;
                     btype_q <= sel_btype;
                     init_q  <= sel_init;
                     rlen_q  <= sel_rlen;
                  end else begin
                     // Rejected descriptor never reaches the serializer.
                     state_q <= StAbrt;
                     done_q  <= sel_gnt;
                     err_q   <= 1'b1;
                  end
               end
            end
            StLoad: begin
               state_q <= StSend;
               fs_q    <= 1'b1;
               wdog_q  <= 16'h0000;
            end
            StSend: begin
               if (tx_fd) begin
                  state_q <= StRels;
                  fs_q    <= 1'b0;
                  done_q  <= gnt_q;
                  if (gnt_q[2] && !retry_q) begin
                     toggle_q <= ~toggle_q;
                  end
               end else if (wdog_q == WdogLast) begin
                  state_q <= StAbrt;
                  fs_q    <= 1'b0;
                  done_q  <= gnt_q;
                  err_q   <= 1'b1;
               end else begin
                  wdog_q <= wdog_q + 16'h0001;
               end
            end
            StAbrt: begin
               state_q <= StRels;
            end
            StRels: begin
               if (!tx_fd) begin
                  state_q <= StGap;
                  gap_q   <= 8'h00;
               end
            end
            StGap: begin
               if (gap_q == GapLast) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  gap_q <= gap_q + 8'h01;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign {dt_done, st_done, hs_done} = done_q;
   assign tx_fs    = fs_q;
   assign tx_btype = btype_q;
   assign tx_init  = init_q;
   assign tx_rlen  = rlen_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule

// File: tb/tb_com_tx_sched.sv
// Bench for com_tx_sched: directed scenarios plus randomized requests checked against a
// transaction-level model of priority, descriptor, toggle, watchdog and gap behaviour.
module tb_com_tx_sched;

   localparam int unsigned GAP = 4;
   localparam int unsigned TO  = 24;

   logic        clk = 1'b0;
   logic        rst;
   logic        hs_req, st_req, dt_req, dt_retry, tx_fd;
   logic [1:0]  hs_type, st_type;
   logic [11:0] st_init, st_rlen, dt_init, dt_rlen;
   logic        hs_done, st_done, dt_done, tx_fs, busy, err;
   logic [3:0]  tx_btype;
   logic [11:0] tx_init, tx_rlen;

   int checks   = 0;
   int failures = 0;

   // Model state: next data PID and the descriptor last forwarded.
   logic        m_toggle;
   logic [3:0]  m_bt;
   logic [11:0] m_init, m_rlen;

   typedef struct {
      bit          ok;
      int          wait_n;
      int          fs_cyc;
      int          busy_lat;
      logic [3:0]  bt;
      logic [11:0] ini;
      logic [11:0] rl;
      logic [3:0]  bt_done;
      logic [2:0]  dn;
      logic [2:0]  dn2;
      logic        er;
   } obs_t;

   com_tx_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .hs_req(hs_req), .hs_type(hs_type), .hs_done(hs_done),
      .st_req(st_req), .st_type(st_type), .st_init(st_init), .st_rlen(st_rlen),
      .st_done(st_done),
      .dt_req(dt_req), .dt_retry(dt_retry), .dt_init(dt_init), .dt_rlen(dt_rlen),
      .dt_done(dt_done),
      .tx_fs(tx_fs), .tx_fd(tx_fd), .tx_btype(tx_btype), .tx_init(tx_init),
      .tx_rlen(tx_rlen), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Acts as serializer and requester for one grant: raises fd after fd_delay fs-high cycles
   // (0 = never), drops the served request at its done pulse, then waits for busy to fall.
   task automatic serve(input int fd_delay, output obs_t o);
      o.ok = 0; o.wait_n = 0; o.fs_cyc = 0; o.busy_lat = 0;
      o.bt = '0; o.ini = '0; o.rl = '0; o.bt_done = '0; o.dn = '0; o.dn2 = '0; o.er = 0;
      do begin
         @(negedge clk);
         o.wait_n++;
      end while (!(tx_fs || hs_done || st_done || dt_done) && o.wait_n < 300);
      if (o.wait_n >= 300) return;
      if (tx_fs) begin
         o.bt = tx_btype; o.ini = tx_init; o.rl = tx_rlen;
         while (tx_fs && o.fs_cyc < 1000) begin
            o.fs_cyc++;
            if (o.fs_cyc == fd_delay) tx_fd = 1'b1;
            @(negedge clk);
         end
      end
      o.dn = {dt_done, st_done, hs_done};
      o.er = err;
      o.bt_done = tx_btype;
      if (hs_done) hs_req = 1'b0;
      if (st_done) st_req = 1'b0;
      if (dt_done) dt_req = 1'b0;
      tx_fd = 1'b0;
      @(negedge clk);
      o.dn2 = {dt_done, st_done, hs_done};
      o.busy_lat = 1;
      while (busy && o.busy_lat < 100) begin
         @(negedge clk);
         o.busy_lat++;
      end
      o.ok = (o.busy_lat < 100);
   endtask

   task automatic send_dt(input logic [11:0] ini, input logic [11:0] rl, input logic retry,
                          input int fd_delay, output obs_t o);
      dt_init = ini; dt_rlen = rl; dt_retry = retry; dt_req = 1'b1;
      serve(fd_delay, o);
      dt_retry = 1'b0;
      if (o.ok && o.fs_cyc != 0 && o.fs_cyc < int'(TO) && !retry) m_toggle = ~m_toggle;
      if (o.ok && o.fs_cyc != 0) begin m_bt = o.bt; m_init = o.ini; m_rlen = o.rl; end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({tx_fs, busy, err, hs_done, st_done, dt_done} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=000000", {tx_fs, busy, err, hs_done, st_done, dt_done});
      end
      checks++;
      if ({tx_btype, tx_init, tx_rlen} !== 28'h0) begin
         failures++;
         $display("FAIL reset_desc got=%h exp=0", {tx_btype, tx_init, tx_rlen});
      end
      m_toggle = 1'b0; m_bt = '0; m_init = '0; m_rlen = '0;
   endtask

   task automatic test_data();
      obs_t o;
      send_dt(12'h040, 12'h010, 1'b0, 20, o);
      checks++;
      if (!o.ok || o.wait_n !== 2 || {o.bt, o.ini, o.rl} !== {4'b1101, 12'h040, 12'h010}) begin
         failures++;
         $display("FAIL data0_desc got=%0d/%h/%h/%h exp=2/d/040/010", o.wait_n, o.bt, o.ini, o.rl);
      end
      checks++;
      if (o.fs_cyc !== 20 || o.dn !== 3'b100 || o.er !== 1'b0 || o.dn2 !== 3'b000) begin
         failures++;
         $display("FAIL data0_done got=fs%0d dn%b er%b dn2%b exp=fs20 dn100 er0 dn2000",
                  o.fs_cyc, o.dn, o.er, o.dn2);
      end
      checks++;
      if (o.busy_lat !== int'(GAP) + 1) begin
         failures++;
         $display("FAIL data0_gap got=%0d exp=%0d", o.busy_lat, GAP + 1);
      end
      send_dt(12'h123, 12'h007, 1'b0, 3, o);
      checks++;
      if (o.bt !== 4'b1110) begin
         failures++;
         $display("FAIL data1_btype got=%b exp=1110", o.bt);
      end
   endtask

   task automatic test_priority();
      obs_t o;
      logic [3:0] exp_bt [3];
      exp_bt[0] = 4'b0010; exp_bt[1] = 4'b1001; exp_bt[2] = m_toggle ? 4'b1110 : 4'b1101;
      hs_type = 2'b10; st_type = 2'b01; st_init = 12'h200; st_rlen = 12'h004;
      dt_init = 12'h300; dt_rlen = 12'h008; dt_retry = 1'b0;
      hs_req = 1'b1; st_req = 1'b1; dt_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         serve(5, o);
         checks++;
         if (!o.ok || o.bt !== exp_bt[i] || o.dn !== 3'(1 << i) || o.busy_lat !== int'(GAP) + 1) begin
            failures++;
            $display("FAIL prio_%0d got=%b dn%b lat%0d exp=%b dn%b lat%0d", i, o.bt, o.dn,
                     o.busy_lat, exp_bt[i], 3'(1 << i), GAP + 1);
         end
      end
      m_toggle = ~m_toggle;
      m_bt = exp_bt[2]; m_init = 12'h300; m_rlen = 12'h008;
   endtask

   task automatic test_retry();
      obs_t o;
      logic prev;
      prev = m_toggle;
      send_dt(12'h010, 12'h020, 1'b0, 4, o);
      send_dt(12'h010, 12'h020, 1'b1, 4, o);
      checks++;
      if (o.bt !== (prev ? 4'b1110 : 4'b1101)) begin
         failures++;
         $display("FAIL retry_btype got=%b exp=%b", o.bt, prev ? 4'b1110 : 4'b1101);
      end
      send_dt(12'h011, 12'h021, 1'b0, 4, o);
      checks++;
      if (o.bt !== (prev ? 4'b1101 : 4'b1110)) begin
         failures++;
         $display("FAIL after_retry_btype got=%b exp=%b", o.bt, prev ? 4'b1101 : 4'b1110);
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      logic prev;
      prev = m_toggle;
      send_dt(12'h055, 12'h066, 1'b0, 0, o);
      checks++;
      if (!o.ok || o.fs_cyc !== int'(TO) || o.dn !== 3'b100 || o.er !== 1'b1) begin
         failures++;
         $display("FAIL timeout got=fs%0d dn%b er%b exp=fs%0d dn100 er1", o.fs_cyc, o.dn, o.er, TO);
      end
      checks++;
      if (o.dn2 !== 3'b000 || o.busy_lat !== int'(GAP) + 2) begin
         failures++;
         $display("FAIL timeout_gap got=dn2%b lat%0d exp=dn2000 lat%0d", o.dn2, o.busy_lat, GAP + 2);
      end
      send_dt(12'h056, 12'h067, 1'b0, 2, o);
      checks++;
      if (o.bt !== (prev ? 4'b1110 : 4'b1101)) begin
         failures++;
         $display("FAIL timeout_toggle got=%b exp=%b", o.bt, prev ? 4'b1110 : 4'b1101);
      end
   endtask

   task automatic test_illegal();
      obs_t o;
      st_type = 2'b01; st_init = 12'h0aa; st_rlen = 12'h000; st_req = 1'b1;
      serve(5, o);
      checks++;
      if (!o.ok || o.fs_cyc !== 0 || o.wait_n !== 1 || o.dn !== 3'b010 || o.er !== 1'b1 ||
          o.bt_done !== m_bt) begin
         failures++;
         $display("FAIL illegal_st got=fs%0d w%0d dn%b er%b bt%b exp=fs0 w1 dn010 er1 bt%b",
                  o.fs_cyc, o.wait_n, o.dn, o.er, o.bt_done, m_bt);
      end
      hs_type = 2'b00; hs_req = 1'b1;
      serve(5, o);
      checks++;
      if (!o.ok || o.fs_cyc !== 0 || o.dn !== 3'b001 || o.er !== 1'b1 ||
          o.busy_lat !== int'(GAP) + 2) begin
         failures++;
         $display("FAIL illegal_hs got=fs%0d dn%b er%b lat%0d exp=fs0 dn001 er1 lat%0d",
                  o.fs_cyc, o.dn, o.er, o.busy_lat, GAP + 2);
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      int n;
      if (!m_toggle) send_dt(12'h001, 12'h002, 1'b0, 3, o);
      dt_init = 12'h0f0; dt_rlen = 12'h00f; dt_req = 1'b1;
      n = 0;
      while (!tx_fs && n < 50) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      rst = 1'b0; dt_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks++;
      if ({tx_fs, busy, tx_btype, tx_init, tx_rlen} !== 30'h0 || n >= 50) begin
         failures++;
         $display("FAIL reset_mid got=%h exp=0", {tx_fs, busy, tx_btype, tx_init, tx_rlen});
      end
      m_toggle = 1'b0; m_bt = '0; m_init = '0; m_rlen = '0;
      send_dt(12'h0f0, 12'h00f, 1'b0, 2, o);
      checks++;
      if (o.bt !== 4'b1101) begin
         failures++;
         $display("FAIL reset_toggle got=%b exp=1101", o.bt);
      end
   endtask

   task automatic test_random();
      obs_t o;
      logic [2:0] pend, win;
      logic       legal, retry;
      logic [3:0] e_bt;
      logic [11:0] e_init, e_rlen;
      int         dly, e_fs;
      for (int it = 0; it < 30; it++) begin
         pend = 3'($urandom_range(1, 7));
         hs_type = 2'($urandom); st_type = 2'($urandom);
         st_init = 12'($urandom); dt_init = 12'($urandom);
         st_rlen = ($urandom % 6 == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
         dt_rlen = ($urandom % 6 == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
         retry = ($urandom % 4 == 0);
         dt_retry = retry;
         {dt_req, st_req, hs_req} = pend;
         while (pend != 3'b000) begin
            win = pend[0] ? 3'b001 : (pend[1] ? 3'b010 : 3'b100);
            e_init = 12'h000; e_rlen = 12'h000;
            if (win == 3'b001) begin
               legal = (hs_type != 0); e_bt = 4'(hs_type);
            end else if (win == 3'b010) begin
               legal = (st_type != 3) && (st_rlen != 0); e_bt = 4'(8 + st_type);
               e_init = st_init; e_rlen = st_rlen;
            end else begin
               legal = (dt_rlen != 0); e_bt = (m_toggle ^ retry) ? 4'd14 : 4'd13;
               e_init = dt_init; e_rlen = dt_rlen;
            end
            dly = ($urandom % 6 == 0) ? 0 : $urandom_range(1, TO - 1);
            e_fs = !legal ? 0 : (dly == 0 ? int'(TO) : dly);
            serve(dly, o);
            checks++;
            if (!o.ok || o.wait_n !== (legal ? 2 : 1) || o.fs_cyc !== e_fs || o.dn !== win ||
                o.er !== (!legal || dly == 0) || o.dn2 !== 3'b000) begin
               failures++;
               $display("FAIL rnd%0d_flow got=w%0d fs%0d dn%b er%b dn2%b exp=w%0d fs%0d dn%b er%b",
                        it, o.wait_n, o.fs_cyc, o.dn, o.er, o.dn2, legal ? 2 : 1, e_fs, win,
                        !legal || dly == 0);
            end
            checks++;
            if (legal ? ({o.bt, o.ini, o.rl} !== {e_bt, e_init, e_rlen}) : (o.bt_done !== m_bt)) begin
               failures++;
               $display("FAIL rnd%0d_desc got=%h/%h/%h bt_done=%h exp=%h/%h/%h held=%h", it, o.bt,
                        o.ini, o.rl, o.bt_done, e_bt, e_init, e_rlen, m_bt);
            end
            checks++;
            if (o.busy_lat !== int'(GAP) + ((!legal || dly == 0) ? 2 : 1)) begin
               failures++;
               $display("FAIL rnd%0d_gap got=%0d exp=%0d", it, o.busy_lat,
                        GAP + ((!legal || dly == 0) ? 2 : 1));
            end
            if (legal) begin m_bt = e_bt; m_init = e_init; m_rlen = e_rlen; end
            if (legal && win == 3'b100 && dly != 0 && !retry) m_toggle = ~m_toggle;
            pend = pend & ~win;
         end
         dt_retry = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b0; tx_fd = 1'b0;
      hs_req = 1'b0; st_req = 1'b0; dt_req = 1'b0; dt_retry = 1'b0;
      hs_type = 2'b01; st_type = 2'b00;
      st_init = '0; st_rlen = '0; dt_init = '0; dt_rlen = '0;
      test_reset();
      test_data();
      test_priority();
      test_retry();
      test_timeout();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
